// File: rtl/fp_div_arbiter.sv
// Round-robin front end sharing one fixed-latency pipelined FP divider among NB_REQ requesters.
// A shadow pipe carries requester ID and tag alongside the divider so each result is routed home.
module fp_div_arbiter #(
    parameter int NB_REQ      = 4,
    parameter int DIV_LATENCY = 2,
    parameter int MAX_OUTST   = 2,
    parameter int FP_WIDTH    = 32,
    parameter int TAG_WIDTH   = 5,
    parameter int RND_WIDTH   = 3,
    parameter int STAT_WIDTH  = 8,
    localparam int ID_W       = ($clog2(NB_REQ) > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NB_REQ-1:0]           req_i,
    input  logic [NB_REQ*FP_WIDTH-1:0]  opa_i,
    input  logic [NB_REQ*FP_WIDTH-1:0]  opb_i,
    input  logic [NB_REQ*RND_WIDTH-1:0] rnd_i,
    input  logic [NB_REQ*TAG_WIDTH-1:0] tag_i,
    output logic [NB_REQ-1:0]           gnt_o,
    output logic [NB_REQ-1:0]           rsp_valid_o,
    output logic [FP_WIDTH-1:0]         rsp_res_o,
    output logic [STAT_WIDTH-1:0]       rsp_status_o,
    output logic [TAG_WIDTH-1:0]        rsp_tag_o,
    output logic                        div_en_o,
    output logic [FP_WIDTH-1:0]         div_opa_o,
    output logic [FP_WIDTH-1:0]         div_opb_o,
    output logic [RND_WIDTH-1:0]        div_rnd_o,
    output logic [ID_W-1:0]             div_tag_o,
    input  logic [FP_WIDTH-1:0]         div_res_i,
    input  logic [STAT_WIDTH-1:0]       div_status_i,
    input  logic [ID_W-1:0]             div_tag_i,
    input  logic                        div_valid_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    genvar gi;

    logic [FP_WIDTH-1:0]   opa_arr [NB_REQ];
    logic [FP_WIDTH-1:0]   opb_arr [NB_REQ];
    logic [RND_WIDTH-1:0]  rnd_arr [NB_REQ];
    logic [TAG_WIDTH-1:0]  tag_arr [NB_REQ];
    logic [CNT_W-1:0]      cnt_reg [NB_REQ];
    logic [NB_REQ-1:0]     elig;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [ID_W-1:0]       winner;
    logic                  found;

    logic                  pipe_v_reg   [DIV_LATENCY];
    logic [ID_W-1:0]       pipe_id_reg  [DIV_LATENCY];
    logic [TAG_WIDTH-1:0]  pipe_tag_reg [DIV_LATENCY];
    logic                  tail_v;
    logic [ID_W-1:0]       tail_id;
    logic [TAG_WIDTH-1:0]  tail_tag;
    logic                  mismatch;
    logic                  busy_pipe;

    logic [NB_REQ-1:0]     rsp_valid_reg;
    logic [NB_REQ-1:0]     rsp_valid_next;
    logic [FP_WIDTH-1:0]   rsp_res_reg;
    logic [STAT_WIDTH-1:0] rsp_status_reg;
    logic [TAG_WIDTH-1:0]  rsp_tag_reg;
    logic                  err_reg;

    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_req
            assign opa_arr[gi]        = opa_i[gi*FP_WIDTH +: FP_WIDTH];
            assign opb_arr[gi]        = opb_i[gi*FP_WIDTH +: FP_WIDTH];
            assign rnd_arr[gi]        = rnd_i[gi*RND_WIDTH +: RND_WIDTH];
            assign tag_arr[gi]        = tag_i[gi*TAG_WIDTH +: TAG_WIDTH];
            assign elig[gi]           = req_i[gi] && (cnt_reg[gi] < CNT_W'(MAX_OUTST));
            assign gnt_o[gi]          = found && (winner == ID_W'(gi));
            assign rsp_valid_next[gi] = tail_v && (tail_id == ID_W'(gi));
        end
    endgenerate

    // Scan starts at rr_ptr and wraps; the first eligible requester wins.
    always_comb begin : arb
        int              sum;
        logic [ID_W-1:0] idx;
        sum    = 0;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            sum = int'(rr_ptr_reg) + k;
            if (sum >= NB_REQ) sum = sum - NB_REQ;
            idx = ID_W'(sum);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign div_en_o  = found;
    assign div_opa_o = found ? opa_arr[winner] : '0;
    assign div_opb_o = found ? opb_arr[winner] : '0;
    assign div_rnd_o = found ? rnd_arr[winner] : '0;
    assign div_tag_o = winner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
        end else if (found) begin
            rr_ptr_reg <= (winner == ID_W'(NB_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DIV_LATENCY; k++) begin
                pipe_v_reg[k]   <= 1'b0;
                pipe_id_reg[k]  <= '0;
                pipe_tag_reg[k] <= '0;
            end
        end else begin
            pipe_v_reg[0]   <= found;
            pipe_id_reg[0]  <= winner;
            pipe_tag_reg[0] <= tag_arr[winner];
            for (int k = 1; k < DIV_LATENCY; k++) begin
                pipe_v_reg[k]   <= pipe_v_reg[k-1];
                pipe_id_reg[k]  <= pipe_id_reg[k-1];
                pipe_tag_reg[k] <= pipe_tag_reg[k-1];
            end
        end
    end

    assign tail_v   = pipe_v_reg[DIV_LATENCY-1];
    assign tail_id  = pipe_id_reg[DIV_LATENCY-1];
    assign tail_tag = pipe_tag_reg[DIV_LATENCY-1];
    assign mismatch = (div_valid_i != tail_v) || (div_valid_i && tail_v && (div_tag_i != tail_id));

    // The tracking pipe is authoritative: every issued op returns exactly once, so counters never drift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_reg  <= '0;
            rsp_res_reg    <= '0;
            rsp_status_reg <= '0;
            rsp_tag_reg    <= '0;
            err_reg        <= 1'b0;
        end else begin
            rsp_valid_reg <= rsp_valid_next;
            if (tail_v) begin
                rsp_res_reg    <= div_res_i;
                rsp_status_reg <= div_status_i;
                rsp_tag_reg    <= tail_tag;
            end
            if (mismatch) err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NB_REQ; k++) cnt_reg[k] <= '0;
        end else begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (gnt_o[k] && !rsp_valid_reg[k]) begin
                    cnt_reg[k] <= cnt_reg[k] + CNT_W'(1);
                end else if (!gnt_o[k] && rsp_valid_reg[k] && (cnt_reg[k] != '0)) begin
                    cnt_reg[k] <= cnt_reg[k] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_pipe = 1'b0;
        for (int k = 0; k < DIV_LATENCY; k++) busy_pipe = busy_pipe | pipe_v_reg[k];
    end

    assign busy_o       = busy_pipe | (|rsp_valid_reg);
    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_res_o    = rsp_res_reg;
    assign rsp_status_o = rsp_status_reg;
    assign rsp_tag_o    = rsp_tag_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: toy fixed-latency divider stub plus a transaction-list reference model.
module tb_fp_div_arbiter;

    localparam int N  = 4;
    localparam int DL = 2;
    localparam int MO = 2;
    localparam int FW = 32;
    localparam int TW = 5;
    localparam int RW = 3;
    localparam int SW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_ni;
    logic [N-1:0]    req;
    logic [N*FW-1:0] opa, opb;
    logic [N*RW-1:0] rnd;
    logic [N*TW-1:0] tag;
    logic [N-1:0]    gnt, rsp_valid;
    logic [FW-1:0]   rsp_res;
    logic [SW-1:0]   rsp_status;
    logic [TW-1:0]   rsp_tag;
    logic            div_en;
    logic [FW-1:0]   div_opa, div_opb;
    logic [RW-1:0]   div_rnd;
    logic [IW-1:0]   div_tag;
    logic [FW-1:0]   div_res;
    logic [SW-1:0]   div_status;
    logic [IW-1:0]   div_tag_ret;
    logic            div_valid;
    logic            busy, err;

    fp_div_arbiter #(
        .NB_REQ(N), .DIV_LATENCY(DL), .MAX_OUTST(MO), .FP_WIDTH(FW),
        .TAG_WIDTH(TW), .RND_WIDTH(RW), .STAT_WIDTH(SW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .opa_i(opa), .opb_i(opb),
        .rnd_i(rnd), .tag_i(tag), .gnt_o(gnt), .rsp_valid_o(rsp_valid),
        .rsp_res_o(rsp_res), .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
        .div_en_o(div_en), .div_opa_o(div_opa), .div_opb_o(div_opb),
        .div_rnd_o(div_rnd), .div_tag_o(div_tag), .div_res_i(div_res),
        .div_status_i(div_status), .div_tag_i(div_tag_ret), .div_valid_i(div_valid),
        .busy_o(busy), .err_o(err)
    );

    // Toy divider: exact for power-of-two operands (1.0/2.0 -> 0.5), arbitrary but deterministic otherwise.
    function automatic logic [FW-1:0] fdiv(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [7:0] e;
        e = a[30:23] - b[30:23] + 8'd127;
        return {a[31] ^ b[31], e, a[22:0] ^ b[22:0]};
    endfunction

    function automatic logic [SW-1:0] fstat(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                            input logic [RW-1:0] r);
        return a[7:0] ^ b[15:8] ^ {5'd0, r};
    endfunction

    logic          env_clr, inj_flip, inj_extra;
    logic          sv   [DL];
    logic [IW-1:0] sid  [DL];
    logic [FW-1:0] sres [DL];
    logic [SW-1:0] sst  [DL];

    // The stub is never reset with the DUT, so ops in flight at reset still come back.
    always @(posedge clk) begin
        if (env_clr) begin
            for (int k = 0; k < DL; k++) begin
                sv[k] <= 1'b0; sid[k] <= '0; sres[k] <= '0; sst[k] <= '0;
            end
        end else begin
            sv[0]   <= div_en;
            sid[0]  <= div_tag;
            sres[0] <= fdiv(div_opa, div_opb);
            sst[0]  <= fstat(div_opa, div_opb, div_rnd);
            for (int k = 1; k < DL; k++) begin
                sv[k] <= sv[k-1]; sid[k] <= sid[k-1]; sres[k] <= sres[k-1]; sst[k] <= sst[k-1];
            end
        end
    end

    assign div_valid   = sv[DL-1] | inj_extra;
    assign div_tag_ret = sid[DL-1] ^ (inj_flip ? IW'(1) : IW'(0));
    assign div_res     = sres[DL-1];
    assign div_status  = sst[DL-1];

    typedef struct {
        int            g;
        int            id;
        logic [TW-1:0] tg;
        logic [FW-1:0] res;
        logic [SW-1:0] st;
    } op_t;

    op_t           ops[$];
    int            cyc, rr_m, win_m, n_vec, n_err;
    logic          err_m;
    logic [FW-1:0] last_res;
    logic [SW-1:0] last_st;
    logic [TW-1:0] last_tag;

    logic          rst_s, inj_flip_s, inj_extra_s;
    logic          req_s [N];
    logic [FW-1:0] opa_s [N];
    logic [FW-1:0] opb_s [N];
    logic [RW-1:0] rnd_s [N];
    logic [TW-1:0] tag_s [N];

    task automatic check_val(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, obs, exp_v);
        end
    endtask

    // An op granted in cycle g occupies its requester for cycles g+1 .. g+DL+1.
    function automatic int outst(input int r);
        int c = 0;
        foreach (ops[i]) if (ops[i].id == r && cyc > ops[i].g && cyc <= ops[i].g + DL + 1) c++;
        return c;
    endfunction

    task automatic step();
        int            w;
        logic [N-1:0]  gnt_e, rv_e;
        logic          tail_v, busy_e, mis;
        logic [IW-1:0] tail_id;
        @(negedge clk);
        rst_ni    = rst_s;
        inj_flip  = inj_flip_s;
        inj_extra = inj_extra_s;
        for (int r = 0; r < N; r++) begin
            req[r]            = req_s[r];
            opa[r*FW +: FW]   = opa_s[r];
            opb[r*FW +: FW]   = opb_s[r];
            rnd[r*RW +: RW]   = rnd_s[r];
            tag[r*TW +: TW]   = tag_s[r];
        end
        #1;
        w = -1; gnt_e = '0; rv_e = '0; tail_v = 1'b0; tail_id = '0; busy_e = 1'b0;
        if (!rst_s) begin
            ops.delete();
            rr_m = 0; err_m = 1'b0; last_res = '0; last_st = '0; last_tag = '0;
            check_val("rst_gnt", gnt, 0);
            check_val("rst_div_en", div_en, 0);
            check_val("rst_rsp_valid", rsp_valid, 0);
            check_val("rst_rsp_res", rsp_res, 0);
            check_val("rst_rsp_status", rsp_status, 0);
            check_val("rst_rsp_tag", rsp_tag, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_err", err, 0);
        end else begin
            for (int k = 0; k < N; k++) begin
                int r;
                r = (rr_m + k) % N;
                if (w < 0 && req_s[r] && outst(r) < MO) w = r;
            end
            if (w >= 0) gnt_e = N'(1) << w;
            foreach (ops[i]) begin
                if (ops[i].g + DL + 1 == cyc) begin
                    rv_e     = rv_e | (N'(1) << ops[i].id);
                    last_res = ops[i].res;
                    last_st  = ops[i].st;
                    last_tag = ops[i].tg;
                end
                if (ops[i].g + DL == cyc) begin
                    tail_v  = 1'b1;
                    tail_id = IW'(ops[i].id);
                end
                if (cyc > ops[i].g && cyc <= ops[i].g + DL + 1) busy_e = 1'b1;
            end
            check_val("gnt", gnt, gnt_e);
            check_val("div_en", div_en, (w >= 0));
            check_val("div_opa", div_opa, (w >= 0) ? opa_s[w] : '0);
            check_val("div_opb", div_opb, (w >= 0) ? opb_s[w] : '0);
            if (w >= 0) begin
                check_val("div_rnd", div_rnd, rnd_s[w]);
                check_val("div_tag", div_tag, w);
            end
            check_val("rsp_valid", rsp_valid, rv_e);
            check_val("rsp_res", rsp_res, last_res);
            check_val("rsp_status", rsp_status, last_st);
            check_val("rsp_tag", rsp_tag, last_tag);
            check_val("busy", busy, busy_e);
            check_val("err", err, err_m);
            if (rv_e != '0)
                $display("cyc=%0d rsp valid=%b tag=%0h res=%08h status=%02h",
                         cyc, rv_e, last_tag, last_res, last_st);
            mis = (div_valid != tail_v) || (div_valid && tail_v && (div_tag_ret != tail_id));
            if (mis) err_m = 1'b1;
            if (w >= 0) begin
                ops.push_back('{g: cyc, id: w, tg: tag_s[w],
                                res: fdiv(opa_s[w], opb_s[w]),
                                st: fstat(opa_s[w], opb_s[w], rnd_s[w])});
                rr_m = (w + 1) % N;
            end
            for (int i = ops.size() - 1; i >= 0; i--)
                if (ops[i].g + DL + 1 <= cyc) ops.delete(i);
        end
        win_m = w;
        cyc++;
    endtask

    task automatic new_op(input int r);
        opa_s[r] = $urandom;
        opb_s[r] = $urandom;
        rnd_s[r] = RW'($urandom);
        tag_s[r] = TW'($urandom);
    endtask

    task automatic clear_req();
        for (int r = 0; r < N; r++) req_s[r] = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_req();
        rst_s = 1'b0;
        step();
        rst_s = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; rr_m = 0; win_m = -1; err_m = 1'b0;
        last_res = '0; last_st = '0; last_tag = '0;
        rst_ni = 1'b0; env_clr = 1'b1; inj_flip = 1'b0; inj_extra = 1'b0;
        req = '0; opa = '0; opb = '0; rnd = '0; tag = '0;
        rst_s = 1'b0; inj_flip_s = 1'b0; inj_extra_s = 1'b0;
        for (int r = 0; r < N; r++) new_op(r);
        clear_req();
        step(); step();
        env_clr = 1'b0;
        rst_s = 1'b1;
        idle(2);

        // Single divide 1.0 / 2.0 from requester 0
        opa_s[0] = 32'h3F800000; opb_s[0] = 32'h40000000; tag_s[0] = 5'd5; rnd_s[0] = '0;
        req_s[0] = 1'b1;
        step();
        check_val("t1_gnt", gnt, 4'b0001);
        req_s[0] = 1'b0;
        idle(2);
        check_val("t1_latency", rsp_valid, 4'b0000);
        step();
        check_val("t1_rsp_valid", rsp_valid, 4'b0001);
        check_val("t1_res", rsp_res, 32'h3F000000);
        check_val("t1_tag", rsp_tag, 5'd5);
        idle(3);

        // Everyone requesting continuously from reset: strict rotation
        pulse_reset();
        for (int r = 0; r < N; r++) req_s[r] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check_val("t2_rotation", gnt, N'(1) << (k % N));
            if (win_m >= 0) new_op(win_m);
        end
        clear_req();
        idle(5);

        // Requester 2 alone: two issues, then stalls on the outstanding limit
        req_s[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check_val("t3_gnt", gnt, ((k % 4) < 2) ? 4'b0100 : 4'b0000);
            check_val("t3_rsp", rsp_valid,
                      (k >= 3 && ((k % 4) == 3 || (k % 4) == 0)) ? 4'b0100 : 4'b0000);
            if (win_m >= 0) new_op(2);
        end
        clear_req();
        idle(5);

        // Reset with two ops in flight; their late results must not respond
        req_s[0] = 1'b1; req_s[1] = 1'b1;
        step();
        if (win_m >= 0) req_s[win_m] = 1'b0;
        step();
        clear_req();
        check_val("t5_busy_before", busy, 1);
        rst_s = 1'b0;
        step();
        check_val("t5_busy_rst", busy, 0);
        rst_s = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("t5_no_rsp", rsp_valid, 4'b0000);
        end
        check_val("t5_stray_err", err, 1);
        pulse_reset();
        check_val("t5_err_cleared", err, 0);

        // Wrong returned ID: flagged, still routed by the tracked ID
        req_s[0] = 1'b1;
        new_op(0);
        step();
        req_s[0] = 1'b0;
        step();
        inj_flip_s = 1'b1;
        step();
        inj_flip_s = 1'b0;
        step();
        check_val("t6_flip_err", err, 1);
        check_val("t6_flip_route", rsp_valid, 4'b0001);
        idle(4);
        check_val("t6_sticky", err, 1);
        pulse_reset();
        check_val("t6_err_cleared", err, 0);

        // Spurious valid pulse with nothing in flight
        inj_extra_s = 1'b1;
        step();
        inj_extra_s = 1'b0;
        step();
        check_val("t6_extra_err", err, 1);
        check_val("t6_extra_no_rsp", rsp_valid, 4'b0000);
        pulse_reset();

        // Random traffic; requests held until granted
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < N; r++) begin
                if (req_s[r] && win_m == r) begin
                    new_op(r);
                    req_s[r] = 1'($urandom_range(0, 1));
                end else if (!req_s[r] && $urandom_range(0, 2) == 0) begin
                    new_op(r);
                    req_s[r] = 1'b1;
                end
            end
            step();
        end
        clear_req();
        idle(5);
        check_val("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
